// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Optional feature macro: MULDIV_DIVZERO_EN adds the DivZero output pulse.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             WriteHi,
    input  logic             WriteLo,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
`ifdef MULDIV_DIVZERO_EN
    ,
    output logic             DivZero
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [WIDTH-1:0]  acc_hi, acc_lo, oper_b, op1_raw;
    logic              is_div, neg_q, neg_r, div_zero;

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    // Operand conditioning at the Start edge: signed ops work on magnitudes.
    logic signed [WIDTH-1:0] opa_s, opb_s;
    logic                    sign1, sign2;
    logic [WIDTH-1:0]        mag1, mag2;

    assign opa_s = Operand1;
    assign opb_s = Operand2;
    assign sign1 = ~Op[0] & (opa_s < 0);
    assign sign2 = ~Op[0] & (opb_s < 0);
    assign mag1  = cond_neg(sign1, Operand1);
    assign mag2  = cond_neg(sign2, Operand2);

    // One iteration step: shift-add for MUL, restoring shift-subtract for DIV.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ok;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, oper_b} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, oper_b});
    assign div_diff  = div_shift[WIDTH-1:0] - oper_b;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (count == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            count <= '0;
            Done  <= 1'b0;
            Hi    <= '0;
            Lo    <= '0;
        end else begin
            state <= state_nxt;
            Done  <= (state == FIX);
            if (state == IDLE) count <= '0;
            else if (state == RUN) count <= count + 1'b1;

            if (state == FIX) begin
                if (is_div) begin
                    // Divide by zero leaves the raw dividend in HI, no sign fix-up.
                    Lo <= div_zero ? '1 : cond_neg(neg_q, acc_lo);
                    Hi <= div_zero ? op1_raw : cond_neg(neg_r, acc_hi);
                end else begin
                    {Hi, Lo} <= cond_neg_wide(neg_q, {acc_hi, acc_lo});
                end
            end else if (state == IDLE && !Start) begin
                if (WriteHi) Hi <= WriteData;
                if (WriteLo) Lo <= WriteData;
            end
        end
    end

    always_ff @(posedge Clk) begin
        case (state)
            IDLE: begin
                if (Start) begin
                    is_div   <= Op[1];
                    neg_q    <= sign1 ^ sign2;
                    neg_r    <= sign1;
                    div_zero <= Op[1] & (Operand2 == '0);
                    op1_raw  <= Operand1;
                    acc_hi   <= '0;
                    acc_lo   <= Op[1] ? mag1 : mag2;
                    oper_b   <= Op[1] ? mag2 : mag1;
                end
            end
            RUN: begin
                if (is_div) begin
                    acc_hi <= div_ok ? div_diff : div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                end else begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                end
            end
            default: ;
        endcase
    end

`ifdef MULDIV_DIVZERO_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) DivZero <= 1'b0;
        else          DivZero <= (state == FIX) & is_div & div_zero;
    end
`endif

endmodule
